// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode/write-back/ALU bundle for the operand fetch stage
interface operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [ADDR_W-1:0] RS_ADDR;
  logic [ADDR_W-1:0] RT_ADDR;
  logic              WB_EN;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [DATA_W-1:0] WB_DATA;
  logic              FLUSH;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] RS;
  logic [DATA_W-1:0] RT;

  // Decode / write-back / ALU side of the stage
  modport master (
    output IN_VALID, RS_ADDR, RT_ADDR, WB_EN, WB_ADDR, WB_DATA, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, RS, RT
  );

  // The operand fetch stage itself
  modport slave (
    input  IN_VALID, RS_ADDR, RT_ADDR, WB_EN, WB_ADDR, WB_DATA, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, RS, RT
  );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file read stage with write-back bypass and held-operand refresh
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic            CLK,
  input logic            RST,
  operand_fetch_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [ADDR_W-1:0] cap_rs;
  logic [ADDR_W-1:0] cap_rt;
  logic [DATA_W-1:0] rs_rd;
  logic [DATA_W-1:0] rt_rd;
  logic              in_ready;
  logic              accept;
  logic              consume;
  logic              wb_write;

  // R0 is never written, so the strobe is qualified here once for all users
  assign wb_write = bus.WB_EN && (bus.WB_ADDR != '0);

  // Register file: reset clears every entry, a write-back coinciding with reset is lost
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[bus.WB_ADDR] <= bus.WB_DATA;
    end
  end

  // Read ports: R0 reads zero, a same-cycle write-back wins over the stored value
  always_comb begin
    rs_rd = regs[bus.RS_ADDR];
    rt_rd = regs[bus.RT_ADDR];
    if (bus.RS_ADDR == '0) begin
      rs_rd = '0;
    end else if (wb_write && (bus.WB_ADDR == bus.RS_ADDR)) begin
      rs_rd = bus.WB_DATA;
    end
    if (bus.RT_ADDR == '0) begin
      rt_rd = '0;
    end else if (wb_write && (bus.WB_ADDR == bus.RT_ADDR)) begin
      rt_rd = bus.WB_DATA;
    end
  end

  // Output slot occupancy register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and next occupancy: flush beats accept, accept beats consume
  always_comb begin
    state_nxt = state;
    in_ready  = (state == ST_EMPTY) || bus.OUT_READY;
    accept    = bus.IN_VALID && in_ready;
    consume   = (state == ST_FULL) && bus.OUT_READY;
    if (bus.FLUSH) begin
      state_nxt = ST_EMPTY;
    end else if (accept) begin
      state_nxt = ST_FULL;
    end else if (consume) begin
      state_nxt = ST_EMPTY;
    end
  end

  // Operand register: load on accept, otherwise track write-backs to the captured sources while held
  always_ff @(posedge CLK) begin
    if (RST) begin
      rs_q   <= '0;
      rt_q   <= '0;
      cap_rs <= '0;
      cap_rt <= '0;
    end else if (!bus.FLUSH) begin
      if (accept) begin
        rs_q   <= rs_rd;
        rt_q   <= rt_rd;
        cap_rs <= bus.RS_ADDR;
        cap_rt <= bus.RT_ADDR;
      end else if ((state == ST_FULL) && !consume) begin
        if (wb_write && (bus.WB_ADDR == cap_rs)) begin
          rs_q <= bus.WB_DATA;
        end
        if (wb_write && (bus.WB_ADDR == cap_rt)) begin
          rt_q <= bus.WB_DATA;
        end
      end
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = (state == ST_FULL);
  assign bus.RS        = rs_q;
  assign bus.RT        = rt_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  operand_fetch_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [2:0] ra, input logic [2:0] ta,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic fl, input logic ordy);
    bus.IN_VALID  = iv;
    bus.RS_ADDR   = ra;
    bus.RT_ADDR   = ta;
    bus.WB_EN     = we;
    bus.WB_ADDR   = wa;
    bus.WB_DATA   = wd;
    bus.FLUSH     = fl;
    bus.OUT_READY = ordy;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.OUT_VALID), 0);
    chk("reset_rs", 32'(bus.RS), 0);
    chk("reset_rt", 32'(bus.RT), 0);
    chk("reset_in_ready", 32'(bus.IN_READY), 1);

    // First read after reset: every register is zero
    drive(1, 3, 5, 0, 0, 16'h0, 0, 0);
    tick();
    chk("rd35_valid", 32'(bus.OUT_VALID), 1);
    chk("rd35_rs", 32'(bus.RS), 16'h0000);
    chk("rd35_rt", 32'(bus.RT), 16'h0000);
    drive(0, 0, 0, 0, 0, 16'h0, 0, 1);
    tick();
    chk("rd35_consumed", 32'(bus.OUT_VALID), 0);

    // Same-cycle write-back visible to the read
    drive(1, 2, 0, 1, 2, 16'hA5A5, 0, 0);
    tick();
    chk("bypass_valid", 32'(bus.OUT_VALID), 1);
    chk("bypass_rs", 32'(bus.RS), 16'hA5A5);
    chk("bypass_rt", 32'(bus.RT), 16'h0000);
    drive(1, 0, 2, 1, 0, 16'hFFFF, 0, 1);
    tick();
    chk("r0_bypass_rs", 32'(bus.RS), 16'h0000);
    chk("r2_stored_rt", 32'(bus.RT), 16'hA5A5);
    drive(1, 0, 0, 0, 0, 16'h0, 0, 1);
    tick();
    chk("r0_stored_rs", 32'(bus.RS), 16'h0000);

    // Load R1..R4 with 1..4, then back-to-back pairs
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 3'(i), 16'(i), 0, 1);
      tick();
    end
    chk("drain_valid", 32'(bus.OUT_VALID), 0);
    drive(1, 1, 2, 0, 0, 16'h0, 0, 1);
    tick();
    chk("b2b0_valid", 32'(bus.OUT_VALID), 1);
    chk("b2b0_rs", 32'(bus.RS), 16'h0001);
    chk("b2b0_rt", 32'(bus.RT), 16'h0002);
    chk("b2b0_in_ready", 32'(bus.IN_READY), 1);
    drive(1, 3, 4, 0, 0, 16'h0, 0, 1);
    tick();
    chk("b2b1_valid", 32'(bus.OUT_VALID), 1);
    chk("b2b1_rs", 32'(bus.RS), 16'h0003);
    chk("b2b1_rt", 32'(bus.RT), 16'h0004);
    drive(1, 1, 4, 0, 0, 16'h0, 0, 1);
    tick();
    chk("b2b2_valid", 32'(bus.OUT_VALID), 1);
    chk("b2b2_rs", 32'(bus.RS), 16'h0001);
    chk("b2b2_rt", 32'(bus.RT), 16'h0004);
    drive(0, 0, 0, 0, 0, 16'h0, 0, 1);
    tick();
    chk("b2b_end_valid", 32'(bus.OUT_VALID), 0);

    // Stall holding (4,4); write-back to R4 refreshes both operands, blocked pair ignored
    drive(1, 4, 4, 0, 0, 16'h0, 0, 0);
    tick();
    chk("stall_rs", 32'(bus.RS), 16'h0004);
    drive(1, 1, 1, 1, 4, 16'h1234, 0, 0);
    #1;
    chk("stall_in_ready", 32'(bus.IN_READY), 0);
    tick();
    chk("refresh_valid", 32'(bus.OUT_VALID), 1);
    chk("refresh_rs", 32'(bus.RS), 16'h1234);
    chk("refresh_rt", 32'(bus.RT), 16'h1234);
    drive(0, 0, 0, 0, 0, 16'h0, 0, 1);
    #1;
    chk("release_in_ready", 32'(bus.IN_READY), 1);
    tick();
    chk("release_consumed", 32'(bus.OUT_VALID), 0);

    // Independent refresh: only RT follows a write to R2
    drive(1, 4, 2, 0, 0, 16'h0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 2, 16'hBEEF, 0, 0);
    tick();
    chk("refresh1_rs", 32'(bus.RS), 16'h1234);
    chk("refresh1_rt", 32'(bus.RT), 16'hBEEF);

    // Flush drops held and incoming pairs, register write still lands
    drive(1, 1, 3, 1, 5, 16'h5555, 1, 1);
    #1;
    chk("flush_in_ready", 32'(bus.IN_READY), 1);
    tick();
    chk("flush_valid", 32'(bus.OUT_VALID), 0);
    drive(1, 5, 3, 0, 0, 16'h0, 0, 0);
    tick();
    chk("post_flush_valid", 32'(bus.OUT_VALID), 1);
    chk("post_flush_rs", 32'(bus.RS), 16'h5555);
    chk("post_flush_rt", 32'(bus.RT), 16'h0003);

    // Reset during a stall, with a write-back that must be lost
    rst = 1'b1;
    drive(0, 0, 0, 1, 6, 16'h6666, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    #1;
    chk("rst_stall_valid", 32'(bus.OUT_VALID), 0);
    chk("rst_stall_rs", 32'(bus.RS), 0);
    chk("rst_stall_rt", 32'(bus.RT), 0);
    drive(1, 4, 6, 0, 0, 16'h0, 0, 1);
    tick();
    chk("rst_r4", 32'(bus.RS), 16'h0000);
    chk("rst_r6", 32'(bus.RT), 16'h0000);
    drive(1, 5, 2, 0, 0, 16'h0, 0, 1);
    tick();
    chk("rst_r5", 32'(bus.RS), 16'h0000);
    chk("rst_r2", 32'(bus.RT), 16'h0000);
    drive(0, 0, 0, 0, 0, 16'h0, 0, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage directly upstream of the ALU operation units (AND/OR/ADD/...). It holds the 8-entry, 16-bit general register file, reads two source registers per instruction with write-back bypass, and presents the RS/RT operands from a one-deep valid/ready output register. A stalled operand is refreshed in place when write-back updates its source register.

## Interface
Parameters:
- DATA_W, 16, operand and register width
- ADDR_W, 3, register address width (2^ADDR_W registers; R0 hardwired zero)

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- IN_VALID  input  1  decode presents a new RS_ADDR/RT_ADDR pair
- IN_READY  output  1  stage accepts the pair this cycle
- RS_ADDR  input  ADDR_W  first source register
- RT_ADDR  input  ADDR_W  second source register
- WB_EN  input  1  write-back strobe
- WB_ADDR  input  ADDR_W  write-back destination
- WB_DATA  input  DATA_W  write-back value
- FLUSH  input  1  discard held operand pair (branch/jump squash)
- OUT_VALID  output  1  RS/RT hold a valid operand pair
- OUT_READY  input  1  ALU consumes the pair this cycle
- RS  output  DATA_W  registered first operand
- RT  output  DATA_W  registered second operand

## Operation
- Register file: 2^ADDR_W x DATA_W. Write on CLK when WB_EN=1 and WB_ADDR!=0. Writes to R0 dropped; R0 always reads 0.
- Read path (combinational into output register): value(a) = 0 if a==0; else WB_DATA if WB_EN and WB_ADDR==a; else regfile[a]. Write-first bypass: same-cycle write is visible to the read.
- Handshake: IN_READY = !OUT_VALID | OUT_READY (combinational from OUT_VALID, OUT_READY; independent of IN_VALID). Accept = IN_VALID & IN_READY.
- On accept (and no FLUSH): RS<=value(RS_ADDR), RT<=value(RT_ADDR), captured addresses CAP_RS/CAP_RT<=RS_ADDR/RT_ADDR, OUT_VALID<=1.
- Consume without accept (OUT_VALID & OUT_READY & !accept): OUT_VALID<=0; RS/RT retain last value.
- Hold refresh: while OUT_VALID=1 and not consumed, if WB_EN and WB_ADDR!=0 and WB_ADDR==CAP_RS, RS<=WB_DATA; same independently for RT. Both refresh when CAP_RS==CAP_RT.
- FLUSH=1: OUT_VALID<=0 next edge; overrides accept and refresh (input pair is dropped even though IN_READY may be 1; decode must treat it as squashed). Register file writes proceed normally during FLUSH.
- Priority per edge: RST > FLUSH > accept > consume > refresh.

## Timing
- Latency: 1 cycle from accept to OUT_VALID=1 with operands.
- Throughput: 1 pair/cycle when OUT_READY held 1.
- Reset (RST=1 at edge): all registers incl. R1..R7 = 0, RS=0, RT=0, CAP_RS=CAP_RT=0, OUT_VALID=0. IN_READY=1 in the first cycle after reset. RST asserted mid-stall discards the held pair; a write-back in the same cycle as RST is discarded.
- OUT_VALID/RS/RT are stable while OUT_VALID=1 and OUT_READY=0, except hold refresh.
- Write at edge N is seen by an accept at edge N (bypass) and all later reads.

## Test plan
- Reset then read: RST 1 cycle, accept RS_ADDR=3, RT_ADDR=5 -> next cycle OUT_VALID=1, RS=0x0000, RT=0x0000.
- Write then bypass: WB R2=0xA5A5 in the same cycle as accept RS_ADDR=2, RT_ADDR=0 -> RS=0xA5A5, RT=0x0000; WB to R0=0xFFFF then read R0 -> 0x0000.
- Back-to-back: OUT_READY=1, accept (1,2),(3,4),(1,4) on consecutive cycles with R1..R4=0x0001..0x0004 -> three consecutive OUT_VALID cycles, pairs (1,2),(3,4),(1,4) values, no bubbles.
- Stall + refresh: OUT_READY=0 holding pair (4,4); WB R4=0x1234 -> RS=RT=0x1234 next cycle, IN_READY=0, OUT_VALID stays 1; release OUT_READY -> pair consumed once.
- Flush: OUT_VALID=1, assert FLUSH with IN_VALID=1, OUT_READY=1 -> OUT_VALID=0 next cycle; following accept proceeds normally.
- Reset mid-stall: OUT_VALID=1, OUT_READY=0, RST=1 -> OUT_VALID=0, RS=RT=0, all registers read 0 afterward.
